// File: rtl/mmio_decoder_n.sv
// mmio_decoder_n: one master fanned out to NSLV windowed slaves; registered decode, one-cycle strobe,
// ready wait with timeout, error response. Error log (err_addr/err_cnt) under `MMIO_DECODER_ERRLOG_EN.
module mmio_decoder_n #(
  parameter int unsigned          NSLV      = 8,
  parameter int unsigned          AW        = 32,
  parameter int unsigned          DW        = 32,
  parameter logic [NSLV*AW-1:0]   SLV_BASE  = '0,
  parameter logic [NSLV*AW-1:0]   SLV_MASK  = {NSLV{32'hff000000}},
  parameter logic [NSLV-1:0]      SLV_NORDY = '0,
  parameter int unsigned          TIMEOUT   = 255,
  parameter logic [DW-1:0]        ERR_DATA  = 32'hdeadbeef
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      a,
  input  logic [DW-1:0]      d,
  input  logic               we,
  input  logic               rd,
  output logic [DW-1:0]      spo,
  output logic               ready,
  output logic               err,
  output logic               irq,
  output logic [AW-1:0]      s_a,
  output logic [DW-1:0]      s_d,
  output logic [NSLV-1:0]    s_we,
  output logic [NSLV-1:0]    s_rd,
  input  logic [NSLV*DW-1:0] s_spo,
  input  logic [NSLV-1:0]    s_ready,
  output logic [AW-1:0]      err_addr,
  output logic [15:0]        err_cnt
);

  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, ERR, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_r_q, a_r_d;
  logic            we_r_q, we_r_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   s_a_q, s_a_d;
  logic [DW-1:0]   s_d_q, s_d_d;
  logic [NSLV-1:0] s_we_q, s_we_d, s_rd_q, s_rd_d;
  logic [DW-1:0]   spo_q, spo_d;
  logic            ready_q, ready_d, err_q, err_d, irq_q, irq_d;

  logic [AW-1:0]   dec_a_c, hit_mask_c;
  logic            hit_c;
  logic [SW-1:0]   hit_sel_c;
  logic [NSLV-1:0] hit_vec_c;
  logic            sel_rdy_c;
  logic [DW-1:0]   sel_spo_c;
  logic            accept_c, go_err_c;

  // Window match, lowest index wins; the live address is decoded at acceptance so s_a is valid in DECODE.
  always_comb begin
    dec_a_c    = (state_q == DECODE) ? a_r_q : a;
    hit_c      = 1'b0;
    hit_sel_c  = '0;
    hit_mask_c = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((dec_a_c & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_c      = 1'b1;
        hit_sel_c  = SW'(i);
        hit_mask_c = SLV_MASK[i*AW +: AW];
      end
    end
    hit_vec_c = NSLV'(1) << hit_sel_c;
  end

  always_comb begin
    sel_rdy_c = 1'b0;
    sel_spo_c = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rdy_c = SLV_NORDY[i] | s_ready[i];
        sel_spo_c = s_spo[i*DW +: DW];
      end
    end
  end

  // Next-state and registered output values.
  always_comb begin
    state_d  = state_q;
    a_r_d    = a_r_q;
    we_r_d   = we_r_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    s_a_d    = s_a_q;
    s_d_d    = s_d_q;
    s_we_d   = '0;
    s_rd_d   = '0;
    spo_d    = spo_q;
    ready_d  = ready_q;
    err_d    = err_q;
    irq_d    = 1'b0;
    go_err_c = 1'b0;
    accept_c = ((state_q == IDLE) || (state_q == RESP)) && (we || rd);

    case (state_q)
      IDLE, RESP: state_d = IDLE;
      DECODE: begin
        if (hit_c) begin
          sel_d   = hit_sel_c;
          s_we_d  = we_r_q ? hit_vec_c : '0;
          s_rd_d  = we_r_q ? '0 : hit_vec_c;
          state_d = ISSUE;
        end else begin
          go_err_c = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_rdy_c) begin
          spo_d   = sel_spo_c;
          ready_d = 1'b1;
          state_d = RESP;
        end else if ((cnt_q + CW'(1)) == TO_LIM) begin
          go_err_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERR: begin
        ready_d = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      a_r_d   = a;
      we_r_d  = we;
      s_a_d   = a & ~hit_mask_c;
      s_d_d   = d;
      ready_d = 1'b0;
      err_d   = 1'b0;
      state_d = DECODE;
    end

    if (go_err_c) begin
      spo_d   = ERR_DATA;
      err_d   = 1'b1;
      irq_d   = 1'b1;
      state_d = ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_r_q   <= '0;
      we_r_q  <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      s_a_q   <= '0;
      s_d_q   <= '0;
      s_we_q  <= '0;
      s_rd_q  <= '0;
      spo_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_r_q   <= a_r_d;
      we_r_q  <= we_r_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      s_a_q   <= s_a_d;
      s_d_q   <= s_d_d;
      s_we_q  <= s_we_d;
      s_rd_q  <= s_rd_d;
      spo_q   <= spo_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign spo   = spo_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign irq   = irq_q;
  assign s_a   = s_a_q;
  assign s_d   = s_d_q;
  assign s_we  = s_we_q;
  assign s_rd  = s_rd_q;

`ifdef MMIO_DECODER_ERRLOG_EN
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  // Log every ERR entry; count saturates.
  always_comb begin
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (irq_d) begin
      err_addr_d = a_r_q;
      if (err_cnt_q != 16'hffff) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`else
  assign err_addr = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/mmio_decoder_n.md
Name: mmio_decoder_n

Overview:
- Parametrised MMIO bus decoder/mux: one master port fanned out to NSLV slaves, each at its own address window (base/mask).
- Latches each master request, decodes it in a registered stage and issues a one-cycle strobe to the selected slave.
- Waits for slave ready, with an optional fixed-latency mode per slave and a bounded timeout.
- Unmapped or timed-out accesses return an error response instead of hanging the bus.
- Sits between the CPU bus interface and the peripheral set (boot ROM, RAM, UART, GPIO, timer, ...).

Parameters:
- NSLV, 8, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {NSLV{32'h0}}, flattened NSLV*AW window bases; slave i at bits [i*AW +: AW].
- SLV_MASK, {NSLV{32'hff000000}}, flattened NSLV*AW compare masks; slave i matches when (a & mask_i) == base_i.
- SLV_NORDY, 0, NSLV-bit mask; bit i set means slave i has no ready and is complete 1 cycle after its strobe.
- TIMEOUT, 255, maximum WAIT cycles before abort; 8-bit counter, valid range 1..255.
- ERR_DATA, 32'hdeadbeef, spo value returned on error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a  in  AW  master address
- d  in  DW  master write data
- we  in  1  write request
- rd  in  1  read request
- spo  out  DW  read data, valid while ready=1 after a read
- ready  out  1  idle/response-valid
- err  out  1  high with ready when the last access errored; cleared by the next request
- irq  out  1  one-cycle pulse per error
- s_a  out  AW  latched address minus window: a_r & ~mask_sel
- s_d  out  DW  latched write data
- s_we  out  NSLV  per-slave write strobe
- s_rd  out  NSLV  per-slave read strobe
- s_spo  in  NSLV*DW  per-slave read data, flattened
- s_ready  in  NSLV  per-slave ready; ignored for SLV_NORDY slaves
- err_addr  out  AW  see Optional Feature
- err_cnt  out  16  see Optional Feature

Behaviour:

Reset:
- state=IDLE; ready=1, err=0, irq=0, spo=0.
- s_we=0, s_rd=0, s_a=0, s_d=0.
- Reset mid-transaction drops any strobe on the next edge and discards the response.

Master handshake:
- Master raises we or rd for exactly one cycle while ready=1.
- If we and rd are both high, it is treated as a write.
- ready deasserts on the cycle after acceptance (registered) and stays low until RESP.
- Requests while ready=0 are ignored.

States:
- IDLE: on (we|rd), latch a_r, d_r, we_r → DECODE.
- DECODE: compute match vector from a_r. Lowest matching index wins, giving sel.
  - No match → ERR.
  - Match → ISSUE.
- ISSUE:
  - Assert s_we[sel]=we_r or s_rd[sel]=~we_r for exactly 1 cycle.
  - Clear timeout counter → WAIT.
- WAIT:
  - If SLV_NORDY[sel] or s_ready[sel]: capture s_spo[sel] into spo → RESP.
  - Else increment counter; when counter==TIMEOUT → ERR.
  - s_ready sampled in the same cycle as the strobe is not valid; WAIT begins the cycle after ISSUE.
- ERR: spo=ERR_DATA, err=1, irq=1 for this cycle only → RESP.
- RESP: ready=1 → IDLE. err and spo hold until the next accepted request.

Latency:
- Request to ready is 4 cycles minimum (IDLE→DECODE→ISSUE→WAIT→RESP) for a no-ready slave.
- Unmapped accesses take 3 cycles.
- Timeouts take TIMEOUT+4 cycles.

Other rules:
- s_a and s_d are held stable from DECODE through RESP.
- On a write, spo carries s_spo[sel], which is don't-care for the master.
- Overlapping windows are legal; priority goes to the lower index.

Optional Feature:
- Macro: MMIO_DECODER_ERRLOG_EN.
- With the macro defined:
  - err_addr latches a_r on every ERR entry.
  - err_cnt is a saturating error counter that stops at 16'hffff.
  - Both are cleared only by rst.
- Without the macro: err_addr=0 and err_cnt=0 constant; no registers are inferred.

Test Plan:
- Read slave 2 (base 32'h92000000, mask ff000000), a=32'h92000014, s_ready[2] high 3 cycles after the s_rd strobe, s_spo=32'h12345678 → single s_rd[2] pulse, s_a=32'h14, ready returns with spo=32'h12345678, err=0.
- Write to a SLV_NORDY slave, a=32'h93000004, d=32'hA5 → s_we[idx] exactly 1 cycle, s_d=32'hA5, ready high 4 cycles after the request.
- Unmapped a=32'h50000000 → no strobe on any slave, spo=32'hdeadbeef, err=1, irq one pulse, ready after 3 cycles; with the macro, err_addr=32'h50000000 and err_cnt=1.
- Slave never asserts ready, TIMEOUT=255 → abort at 259 cycles, err=1, spo=ERR_DATA; the next normal access clears err.
- Overlapping windows: slaves 1 and 3 both match → only s_rd[1] pulses.
- rst asserted during WAIT → next cycle ready=1, all strobes 0, err=0; a fresh request completes normally.
